// File: rtl/zx_keys_pkg.sv
// Shared PS/2 set-2 hotkey definitions: scan codes, key-state bit positions,
// reset FSM encoding and the combo decode used by the hotkey controller.
package zx_keys_pkg;

  localparam logic [7:0] SC_F5     = 8'h03;
  localparam logic [7:0] SC_F11    = 8'h78;
  localparam logic [7:0] SC_F12    = 8'h07;
  localparam logic [7:0] SC_BS     = 8'h66;
  localparam logic [7:0] SC_DEL    = 8'h71;
  localparam logic [7:0] SC_ALT    = 8'h11;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_SCRLCK = 8'h7E;

  localparam int K_F5     = 0;
  localparam int K_F11    = 1;
  localparam int K_F12    = 2;
  localparam int K_BS     = 3;
  localparam int K_DEL    = 4;
  localparam int K_ALT    = 5;
  localparam int K_CTRL   = 6;
  localparam int K_SCRLCK = 7;
  localparam int NKEYS    = 8;

  typedef enum logic [1:0] {
    RST_IDLE  = 2'd0,
    RST_PULSE = 2'd1,
    RST_HELD  = 2'd2
  } rst_state_t;

  // One-hot key-state position for a scan code; zero for codes we ignore.
  function automatic logic [NKEYS-1:0] key_mask(input logic [7:0] code);
    logic [NKEYS-1:0] m;
    m = '0;
    case (code)
      SC_F5:     m[K_F5]     = 1'b1;
      SC_F11:    m[K_F11]    = 1'b1;
      SC_F12:    m[K_F12]    = 1'b1;
      SC_BS:     m[K_BS]     = 1'b1;
      SC_DEL:    m[K_DEL]    = 1'b1;
      SC_ALT:    m[K_ALT]    = 1'b1;
      SC_CTRL:   m[K_CTRL]   = 1'b1;
      SC_SCRLCK: m[K_SCRLCK] = 1'b1;
      default:   m = '0;
    endcase
    return m;
  endfunction

  function automatic logic rst_combo(input logic [NKEYS-1:0] keys);
    return keys[K_F12] | (keys[K_CTRL] & keys[K_ALT] & keys[K_DEL]);
  endfunction

  function automatic logic boot_combo(input logic [NKEYS-1:0] keys);
    return keys[K_F11] | (keys[K_CTRL] & keys[K_ALT] & keys[K_BS]);
  endfunction

endpackage

// File: rtl/hotkey_decode.sv
// Scan-code to key-state register: each recognised code's bit follows the
// make/break flag of its strobe; all other codes leave the state untouched.
module hotkey_decode
  import zx_keys_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       kstb,
  input  logic       make,
  input  logic [7:0] code,
  output logic [7:0] keys
);

  logic [NKEYS-1:0] mask;

  assign mask = key_mask(code);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      keys <= '0;
    end else if (ce && kstb) begin
      keys <= (keys & ~mask) | (mask & {NKEYS{make}});
    end
  end

endmodule

// File: rtl/hotkey_ctrl.sv
// Keyboard hotkey controller: reset-request FSM with a guaranteed minimum
// pulse, long-hold multiboot request, F5 NMI and scroll-lock video toggle.
module hotkey_ctrl
  import zx_keys_pkg::*;
#(
  parameter int PULSE = 16,
  parameter int HOLD  = 7000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       ce,
  input  logic       kstb,
  input  logic       make,
  input  logic [7:0] code,
  input  logic       biosValid,
  input  logic       biosVga,
  output logic       rstReq,
  output logic       bootReq,
  output logic       nmiReq,
  output logic       vga,
  output logic [7:0] keys
);

  localparam int PW = (PULSE > 1) ? $clog2(PULSE) : 1;
  localparam int BW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(PULSE - 1);
  localparam logic [BW-1:0] HOLD_LAST  = BW'(HOLD - 1);

  rst_state_t    state;
  logic [PW-1:0] pulse_cnt;
  logic [BW-1:0] hold_cnt;
  logic          rst_hit;
  logic          boot_hit;
  logic          scrl_press;

  hotkey_decode u_decode (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .kstb  (kstb),
    .make  (make),
    .code  (code),
    .keys  (keys)
  );

  assign rst_hit  = rst_combo(keys);
  assign boot_hit = boot_combo(keys);

  // A fresh press only: typematic repeats arrive while the key is already held.
  assign scrl_press = kstb && make && (code == SC_SCRLCK) && !keys[K_SCRLCK];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= RST_IDLE;
      pulse_cnt <= '0;
      rstReq    <= 1'b0;
    end else if (ce) begin
      case (state)
        RST_IDLE: begin
          if (rst_hit) begin
            state     <= RST_PULSE;
            pulse_cnt <= '0;
            rstReq    <= 1'b1;
          end
        end
        RST_PULSE: begin
          // The combo is ignored until the minimum width has elapsed.
          if (pulse_cnt == PULSE_LAST) begin
            if (rst_hit) begin
              state  <= RST_HELD;
              rstReq <= 1'b1;
            end else begin
              state  <= RST_IDLE;
              rstReq <= 1'b0;
            end
          end else begin
            pulse_cnt <= pulse_cnt + 1'b1;
          end
        end
        RST_HELD: begin
          if (!rst_hit) begin
            state  <= RST_IDLE;
            rstReq <= 1'b0;
          end
        end
        default: begin
          state  <= RST_IDLE;
          rstReq <= 1'b0;
        end
      endcase
    end
  end

  // Hold counter parks at its last value so a long hold never wraps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      bootReq  <= 1'b0;
    end else if (ce) begin
      if (!boot_hit) begin
        hold_cnt <= '0;
      end else if (hold_cnt == HOLD_LAST) begin
        bootReq <= 1'b1;
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      nmiReq <= 1'b0;
      vga    <= 1'b0;
    end else if (ce) begin
      nmiReq <= keys[K_F5];
      if (biosValid) begin
        vga <= biosVga;
      end else if (scrl_press) begin
        vga <= ~vga;
      end
    end
  end

endmodule

// File: tb/tb_hotkey_ctrl.sv
// Bench for hotkey_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a behavioural key/timer model.
module tb_hotkey_ctrl;

  localparam int PULSE = 16;
  localparam int HOLD  = 100;

  logic       clock = 1'b0;
  logic       reset;
  logic       ce;
  logic       kstb;
  logic       make;
  logic [7:0] code;
  logic       biosValid;
  logic       biosVga;
  logic       rstReq;
  logic       bootReq;
  logic       nmiReq;
  logic       vga;
  logic [7:0] keys;

  hotkey_ctrl #(.PULSE(PULSE), .HOLD(HOLD)) dut (
    .clock     (clock),
    .reset     (reset),
    .ce        (ce),
    .kstb      (kstb),
    .make      (make),
    .code      (code),
    .biosValid (biosValid),
    .biosVga   (biosVga),
    .rstReq    (rstReq),
    .bootReq   (bootReq),
    .nmiReq    (nmiReq),
    .vga       (vga),
    .keys      (keys)
  );

  always #9 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic s, input logic m, input logic [7:0] cd);
    ce = c; kstb = s; make = m; code = cd;
    @(posedge clock);
    #1;
    ce = 1'b1; kstb = 1'b0; make = 1'b0; code = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic do_reset();
    reset = 1'b1; biosValid = 1'b0; biosVga = 1'b0;
    idle(2);
    reset = 1'b0;
  endtask

  // Behavioural model: which scan codes are down, plus plain tick counters.
  bit held [256];
  bit m_act;
  int m_rem;
  int m_run;
  bit m_boot, m_nmi, m_vga;

  function automatic logic [7:0] m_keys();
    return {held[8'h7E], held[8'h14], held[8'h11], held[8'h71],
            held[8'h66], held[8'h07], held[8'h78], held[8'h03]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 256; i++) held[i] = 1'b0;
    m_act = 0; m_rem = 0; m_run = 0; m_boot = 0; m_nmi = 0; m_vga = 0;
  endtask

  task automatic model_tick(input bit c, input bit s, input bit m, input logic [7:0] cd,
                            input bit bv, input bit bvga);
    bit rc, bc;
    if (!c) return;
    rc = held[8'h07] || (held[8'h14] && held[8'h11] && held[8'h71]);
    bc = held[8'h78] || (held[8'h14] && held[8'h11] && held[8'h66]);
    if (!m_act) begin
      if (rc) begin m_act = 1; m_rem = PULSE; end
    end else if (m_rem > 1) begin
      m_rem--;
    end else begin
      m_act = rc;
    end
    m_run = bc ? m_run + 1 : 0;
    if (m_run >= HOLD) m_boot = 1;
    m_nmi = held[8'h03];
    if (bv) m_vga = bvga;
    else if (s && m && cd == 8'h7E && !held[8'h7E]) m_vga = !m_vga;
    if (s) held[cd] = m;
  endtask

  typedef struct {
    logic       ce;
    logic       kstb;
    logic       make;
    logic [7:0] code;
    logic       bv;
    logic       bvga;
    logic [7:0] ek;
    logic       en;
    logic       ev;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic c, logic s, logic m, logic [7:0] cd, logic bv, logic bvga,
                              logic [7:0] ek, logic en, logic ev);
    vec_t v;
    v.ce = c; v.kstb = s; v.make = m; v.code = cd; v.bv = bv; v.bvga = bvga;
    v.ek = ek; v.en = en; v.ev = ev;
    return v;
  endfunction

  logic [7:0] codes [8] = '{8'h03, 8'h78, 8'h07, 8'h66, 8'h71, 8'h11, 8'h14, 8'h7E};

  initial begin
    int cnt;
    string nm;
    reset = 1'b1; ce = 1'b0; kstb = 1'b0; make = 1'b0; code = 8'h00;
    biosValid = 1'b0; biosVga = 1'b0;
    #5;
    check("reset_rst",  rstReq,  1'b0);
    check("reset_boot", bootReq, 1'b0);
    check("reset_nmi",  nmiReq,  1'b0);
    check("reset_vga",  vga,     1'b0);
    check("reset_keys", keys,    8'h00);
    do_reset();

    //          ce   kstb make code   bv  bvga keys   nmi vga
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h03, 0, 0, 8'h01, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h5A, 0, 0, 8'h01, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h03, 0, 0, 8'h01, 1, 0));
    tbl.push_back(mk(1, 1, 0, 8'h03, 0, 0, 8'h00, 1, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 0, 0, 8'h00, 1, 1, 8'h00, 0, 1));
    tbl.push_back(mk(1, 1, 1, 8'h7E, 0, 0, 8'h80, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h7E, 0, 0, 8'h80, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h7E, 0, 0, 8'h80, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h7E, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h7E, 0, 0, 8'h80, 0, 1));
    tbl.push_back(mk(1, 1, 0, 8'h7E, 1, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h7E, 1, 0, 8'h80, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h7E, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 1, 8'h7E, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h66, 0, 0, 8'h08, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h71, 0, 0, 8'h18, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h66, 0, 0, 8'h10, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h71, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h14, 0, 0, 8'h40, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h11, 0, 0, 8'h60, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h14, 0, 0, 8'h20, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h11, 0, 0, 8'h00, 0, 0));
    tbl.push_back(mk(1, 1, 1, 8'h78, 0, 0, 8'h02, 0, 0));
    tbl.push_back(mk(1, 1, 0, 8'h78, 0, 0, 8'h00, 0, 0));

    foreach (tbl[i]) begin
      biosValid = tbl[i].bv; biosVga = tbl[i].bvga;
      step(tbl[i].ce, tbl[i].kstb, tbl[i].make, tbl[i].code);
      nm = $sformatf("tbl%0d_keys", i); check(nm, keys,   tbl[i].ek);
      nm = $sformatf("tbl%0d_nmi", i);  check(nm, nmiReq, tbl[i].en);
      nm = $sformatf("tbl%0d_vga", i);  check(nm, vga,    tbl[i].ev);
    end
    biosValid = 1'b0;

    // F12 tap: minimum-width pulse even though released early.
    do_reset();
    step(1, 1, 1, 8'h07);
    check("f12_latency", rstReq, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) step(1, 1, 0, 8'h07); else idle(1);
      if (i == 0) check("f12_first", rstReq, 1'b1);
      if (rstReq) cnt++;
    end
    check("f12_width", cnt, PULSE);
    check("f12_end", rstReq, 1'b0);

    // Ctrl-Alt-Del held 40 ticks, drops one tick after del release.
    do_reset();
    step(1, 1, 1, 8'h14);
    step(1, 1, 1, 8'h11);
    step(1, 1, 1, 8'h71);
    check("cad_latency", rstReq, 1'b0);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      idle(1);
      if (rstReq) cnt++;
    end
    check("cad_width", cnt, 40);
    step(1, 1, 0, 8'h71);
    check("cad_release_edge", rstReq, 1'b1);
    idle(1);
    check("cad_dropped", rstReq, 1'b0);

    // Boot hold: one tick short, then exactly long enough; sticky afterwards.
    do_reset();
    step(1, 1, 1, 8'h78);
    idle(98);
    check("boot_short_mid", bootReq, 1'b0);
    step(1, 1, 0, 8'h78);
    check("boot_short_rel", bootReq, 1'b0);
    idle(3);
    step(1, 1, 1, 8'h78);
    idle(99);
    check("boot_full_pre", bootReq, 1'b0);
    step(1, 1, 0, 8'h78);
    check("boot_full_set", bootReq, 1'b1);
    idle(5);
    check("boot_sticky", bootReq, 1'b1);

    // Reset mid-pulse aborts everything; combo must be re-struck.
    do_reset();
    step(1, 1, 1, 8'h07);
    idle(5);
    check("abort_pre", rstReq, 1'b1);
    reset = 1'b1;
    #2;
    check("abort_rst",  rstReq,  1'b0);
    check("abort_boot", bootReq, 1'b0);
    check("abort_nmi",  nmiReq,  1'b0);
    check("abort_vga",  vga,     1'b0);
    check("abort_keys", keys,    8'h00);
    idle(2);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      idle(1);
      if (rstReq) cnt++;
    end
    check("abort_quiet", cnt, 0);
    step(1, 1, 1, 8'h07);
    idle(1);
    check("abort_restrike", rstReq, 1'b1);

    // Both combos at once act independently.
    do_reset();
    step(1, 1, 1, 8'h07);
    step(1, 1, 1, 8'h78);
    idle(120);
    check("both_rst",  rstReq,  1'b1);
    check("both_boot", bootReq, 1'b1);

    // Randomized run against the model.
    model_reset();
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      bit c, s, m, bv, bvga;
      logic [7:0] cd;
      c    = ($urandom_range(0, 3) != 0);
      s    = ($urandom_range(0, 2) == 0);
      m    = ($urandom_range(0, 9) < 6);
      cd   = ($urandom_range(0, 19) < 17) ? codes[$urandom_range(0, 7)] : 8'($urandom_range(0, 255));
      bv   = ($urandom_range(0, 29) == 0);
      bvga = $urandom_range(0, 1);
      biosValid = bv; biosVga = bvga;
      model_tick(c, s, m, cd, bv, bvga);
      step(c, s, m, cd);
      check("rnd_keys", keys,    m_keys());
      check("rnd_rst",  rstReq,  m_act);
      check("rnd_boot", bootReq, m_boot);
      check("rnd_nmi",  nmiReq,  m_nmi);
      check("rnd_vga",  vga,     m_vga);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hotkey_ctrl.md
HOTKEY_CTRL -- requirements
Module: hotkey_ctrl

Interface
REQ-001 Parameter PULSE, default 16: minimum reset-request width in ce ticks.
REQ-002 Parameter HOLD, default 7000000: boot combo hold time in ce ticks (1 s at 7 MHz).
REQ-003 clock  input  1  system clock (56 MHz).
REQ-004 reset  input  1  reset, asynchronous, active-high.
REQ-005 ce  input  1  clock enable (7 MHz tick); all state, except async reset, changes only when ce=1.
REQ-006 kstb  input  1  PS/2 code strobe, qualified by ce.
REQ-007 make  input  1  1 = key press, 0 = key release; valid with kstb.
REQ-008 code  input  8  PS/2 set-2 scan code; valid with kstb.
REQ-009 biosValid  input  1  flash boot-config read complete; level.
REQ-010 biosVga  input  1  VGA preference from flash; valid while biosValid=1.
REQ-011 rstReq  output  1  core reset request, active-high.
REQ-012 bootReq  output  1  multiboot request, active-high, sticky.
REQ-013 nmiReq  output  1  NMI request, active-high.
REQ-014 vga  output  1  1 = scandoubled VGA, 0 = 15 kHz RGB.
REQ-015 keys  output  8  held state {scrlck,ctrl,alt,del,bs,F12,F11,F5}, MSB first, 1 = held.

Function
REQ-016 On ce&kstb, the key bit matching code SHALL take make: F5 03h, F11 78h, F12 07h, bs 66h, del 71h, alt 11h, ctrl 14h, scrlck 7Eh; other codes SHALL be ignored.
REQ-017 nmiReq SHALL equal keys[F5], registered, with one ce tick latency from the F5 strobe.
REQ-018 rstCombo = F12 | (ctrl&alt&del); bootCombo = F11 | (ctrl&alt&bs); both combinational from keys.
REQ-019 Reset FSM states: IDLE, PULSE, HELD; rstReq=1 in PULSE and HELD.
REQ-020 IDLE->PULSE when rstCombo=1; counter cleared.
REQ-021 PULSE: counter increments per ce; at PULSE-1 go to HELD if rstCombo=1, else IDLE; combo release during PULSE SHALL NOT shorten rstReq.
REQ-022 HELD->IDLE on the ce tick rstCombo is seen 0.
REQ-023 Boot counter: increments per ce while bootCombo=1, clears to 0 when bootCombo=0; at HOLD-1 sets bootReq.
REQ-024 bootReq, once set, SHALL remain 1 until reset; counter saturates and SHALL NOT wrap.
REQ-025 vga SHALL load biosVga on every ce tick with biosValid=1, overriding toggles.
REQ-026 With biosValid=0, a scrlck press (kstb, make=1, code 7Eh, keys[scrlck]=0 beforehand) SHALL toggle vga; typematic repeat makes while held SHALL NOT toggle.
REQ-027 Simultaneous rstCombo and bootCombo: both paths SHALL act independently.
REQ-028 kstb with ce=0 SHALL be ignored.

Reset
REQ-029 On reset: keys=0, rstReq=0, bootReq=0, nmiReq=0, vga=0, FSM=IDLE, all counters 0.
REQ-030 Reset mid-PULSE or mid-hold SHALL abort immediately; a still-held combo SHALL restart from scratch after reset deasserts, with keys relearned only from new strobes.

Structure
REQ-031 Scan-code constants, key bit indices and FSM state encoding SHALL reside in shared package zx_keys_pkg.
REQ-032 Boot hold counter width SHALL be $clog2(HOLD); reset pulse counter width SHALL be $clog2(PULSE).
REQ-033 One sub-module, hotkey_decode (scan code to key-state register), is permitted; timing and FSMs stay in hotkey_ctrl.

Verification
REQ-034 Press 07h, release after 3 ce -> rstReq high for exactly 16 ce ticks, then 0.
REQ-035 Press 14h,11h,71h; hold 40 ce; release 71h -> rstReq high 40+ ticks, drops one tick after release.
REQ-036 Test with HOLD=100: press 78h, release at tick 99 -> bootReq=0; press again for 100 ticks -> bootReq=1 and stays 1 after release.
REQ-037 biosValid=1 with biosVga=1 -> vga=1; biosValid=0, scrlck make x3 (repeat) then break then make -> vga 1->0->1.
REQ-038 Assert reset during PULSE with F12 held -> all outputs 0 at once; after release, no rstReq until a new 07h make.
REQ-039 Strobe 03h make, then unknown code 5Ah -> nmiReq=1 one tick later, keys=01h unchanged by 5Ah.
